// File: rtl/booth_radix4_mult_if.sv
// Operand/result bus of the radix-4 Booth multiplier.
// Ports: bgn, inbus (master -> slave); done, outbus (slave -> master).
interface booth_radix4_mult_if;
   logic       bgn;
   logic [7:0] inbus;
   logic       done;
   logic [8:0] outbus;

   modport master (
      output bgn,
      output inbus,
      input  done,
      input  outbus
   );

   modport slave (
      input  bgn,
      input  inbus,
      output done,
      output outbus
   );
endinterface

// File: rtl/booth_radix4_mult.sv
// Sequential 8x8 signed multiplier, radix-4 Booth, 4 add/shift pairs.
// Ports: clk, rst_b (sync active-high reset), bus (slave: bgn/inbus in,
// done/outbus out; product leaves as A[8:0] then {0,Q}).
module booth_radix4_mult (
   input  logic               clk,
   input  logic               rst_b,
   booth_radix4_mult_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_M,
      S_LOAD_Q,
      S_ADD,
      S_SHIFT,
      S_OUT_A,
      S_OUT_Q,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  a_q, a_d;
   logic [7:0]  m_q, m_d;
   logic [7:0]  q_q, q_d;
   logic        qm1_q, qm1_d;
   logic [1:0]  cnt_q, cnt_d;

   logic [9:0]  m_ext;
   logic [9:0]  opnd;
   logic        neg;
   logic [9:0]  addend;
   logic [20:0] shifted;

   assign m_ext  = {{2{m_q[7]}}, m_q};
   // Subtraction is the inverted operand plus a carry-in of one.
   assign addend = neg ? ~opnd : opnd;
   // A[9] is replicated into the two MSBs vacated by the shift.
   assign shifted = {{2{a_q[9]}}, a_q, q_q, qm1_q};

   always_comb begin
      opnd = '0;
      neg  = 1'b0;
      unique case ({q_q[1:0], qm1_q})
         3'b001, 3'b010: opnd = m_ext;
         3'b011:         opnd = {m_ext[8:0], 1'b0};
         3'b100: begin
            opnd = {m_ext[8:0], 1'b0};
            neg  = 1'b1;
         end
         3'b101, 3'b110: begin
            opnd = m_ext;
            neg  = 1'b1;
         end
         default: opnd = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      m_d     = m_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.bgn) state_d = S_LOAD_M;
         end
         S_LOAD_M: begin
            m_d     = bus.inbus;
            a_d     = '0;
            qm1_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_LOAD_Q;
         end
         S_LOAD_Q: begin
            q_d     = bus.inbus;
            state_d = S_ADD;
         end
         S_ADD: begin
            a_d     = a_q + addend + {9'd0, neg};
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            a_d     = shifted[20:11];
            q_d     = shifted[10:3];
            qm1_d   = shifted[2];
            cnt_d   = cnt_q + 2'd1;
            state_d = (cnt_q == 2'd3) ? S_OUT_A : S_ADD;
         end
         S_OUT_A: state_d = S_OUT_Q;
         S_OUT_Q: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         m_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      bus.done   = 1'b0;
      bus.outbus = '0;
      unique case (state_q)
         S_OUT_A: bus.outbus = a_q[8:0];
         S_OUT_Q: bus.outbus = {1'b0, q_q};
         S_DONE:  bus.done   = 1'b1;
         default: bus.outbus = '0;
      endcase
   end

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Scoreboard bench for booth_radix4_mult.
// Expected products queued at start, checked when done pulses.
module tb_booth_radix4_mult;

   logic clk = 1'b0;
   logic rst_b = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;
   logic [17:0] sb_q[$];

   booth_radix4_mult_if bus ();

   booth_radix4_mult dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [17:0] got,
                        input logic [17:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] model(input logic [7:0] a,
                                         input logic [7:0] b);
      logic signed [15:0] p;
      p = $signed(a) * $signed(b);
      return {p[15], p[15:8], 1'b0, p[7:0]};
   endfunction

   // Monitor: the two beats before the done cycle are OUT_A and OUT_Q.
   logic [8:0] h1 = '0;
   logic [8:0] h2 = '0;
   logic       prev_done = 1'b0;
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         check("done_pulse", {17'd0, prev_done}, 18'd0);
         check("done_outbus", {9'd0, bus.outbus}, 18'd0);
         if (sb_q.size() == 0) begin
            check("sb_empty", 18'd1, 18'd0);
         end else begin
            check("product", {h2, h1}, sb_q.pop_front());
         end
      end
      prev_done = bus.done;
      h2 = h1;
      h1 = bus.outbus;
   end

   // One run: bgn presented for the next edge, operands on the
   // following two edges; latency and idle-zero outbus checked here.
   task automatic run(input logic [7:0] a, input logic [7:0] b,
                      input bit hold, input string tag);
      int k;
      int nz;
      @(negedge clk);
      bus.bgn   = 1'b1;
      bus.inbus = a;
      sb_q.push_back(model(a, b));
      nz = 0;
      for (k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (!hold) bus.bgn = 1'b0;
         if (k == 2) bus.inbus = b;
         if (k == 3) bus.inbus = 8'($urandom);
         if (k <= 10 && bus.outbus != 9'd0) nz++;
         if (bus.done === 1'b1) break;
      end
      check({tag, "_lat"}, 18'(k), 18'd13);
      check({tag, "_zero"}, 18'(nz), 18'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.bgn   = 1'b0;
      bus.inbus = 8'h00;
      rst_b     = 1'b1;
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
      check("rst_done", {17'd0, bus.done}, 18'd0);
      check("rst_outbus", {9'd0, bus.outbus}, 18'd0);
      repeat (3) @(negedge clk);
      check("idle_outbus", {9'd0, bus.outbus}, 18'd0);

      run(8'hE5, 8'h9F, 1'b0, "m27x97");
      run(8'h03, 8'h05, 1'b0, "3x5");
      run(8'h80, 8'h80, 1'b0, "n128sq");
      run(8'h7F, 8'h80, 1'b0, "127xn128");
      run(8'h00, 8'hFF, 1'b0, "zero");
      run(8'hFF, 8'hFF, 1'b0, "n1sq");

      // bgn held high: next run is accepted on the edge after DONE.
      run(8'h5A, 8'hC3, 1'b1, "hold1");
      run(8'h81, 8'h7F, 1'b0, "hold2");

      for (int i = 0; i < 8; i++) begin
         run(8'($urandom), 8'($urandom), 1'b0, "rand");
      end

      // Reset during the third SHIFT (cycle 8 after the start edge).
      @(negedge clk);
      bus.bgn   = 1'b1;
      bus.inbus = 8'h33;
      @(negedge clk);
      bus.bgn = 1'b0;
      @(negedge clk);
      bus.inbus = 8'h44;
      repeat (6) @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      check("mid_rst_done", {17'd0, bus.done}, 18'd0);
      check("mid_rst_out", {9'd0, bus.outbus}, 18'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.outbus !== 9'd0) seen++;
         end
         check("mid_rst_quiet", 18'(seen), 18'd0);
      end
      run(8'hE5, 8'h9F, 1'b0, "post_rst");

      repeat (3) @(negedge clk);
      check("sb_drain", 18'(sb_q.size()), 18'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
